// File: rtl/seq_limb_mul_pkg.sv
// Shared types and helpers for the sequential limb multiplier.
package seq_limb_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PIPE = 2'd2
    } state_t;

    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seq_limb_mul_limb.sv
// Combinational LIMB x LIMB unsigned multiplier; the single shared arithmetic unit.
module limb_mul #(
    parameter int LIMB = 12
) (
    input  logic [LIMB-1:0]   input0,
    input  logic [LIMB-1:0]   input1,
    output logic [2*LIMB-1:0] output0
);

    assign output0 = {{LIMB{1'b0}}, input0} * {{LIMB{1'b0}}, input1};

endmodule

// File: rtl/seq_limb_mul.sv
// WIDTH x WIDTH unsigned multiply by time-sharing one limb multiplier over K*K steps.
// Optional SEQ_LIMB_MUL_PIPE_EN registers the limb product and adds one drain step.
module seq_limb_mul
    import seq_limb_mul_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int LIMB  = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   input0,
    input  logic [WIDTH-1:0]   input1,
    output logic               busy,
    output logic               ready,
    output logic [2*WIDTH-1:0] output0
);

    localparam int K   = WIDTH / LIMB;
    localparam int NPP = K * K;
    localparam int CW  = cnt_width(NPP);
    localparam int PW  = 2 * WIDTH;
    localparam int SW  = $clog2(PW);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CW-1:0]     r_n;
    logic [WIDTH-1:0]  r_opa;
    logic [WIDTH-1:0]  r_opb;
    logic [PW-1:0]     r_acc;
    logic [PW-1:0]     r_out;
    logic              r_ready;

    logic [CW-1:0]     w_i;
    logic [CW-1:0]     w_j;
    logic              w_last;
    logic [LIMB-1:0]   w_a;
    logic [LIMB-1:0]   w_b;
    logic [2*LIMB-1:0] w_pp;
    logic [SW-1:0]     w_shamt;
    logic [PW-1:0]     w_add;
    logic [PW-1:0]     w_sum;

`ifdef SEQ_LIMB_MUL_PIPE_EN
    logic [2*LIMB-1:0] r_pp;
    logic [SW-1:0]     r_shamt;
`endif

    // Limb A index varies fastest: step n selects a[n mod K], b[n div K].
    always_comb begin
        w_i     = r_n % CW'(K);
        w_j     = r_n / CW'(K);
        w_last  = (r_n == CW'(NPP - 1));
        w_a     = r_opa[0 +: LIMB];
        w_b     = r_opb[0 +: LIMB];
        w_shamt = '0;
        if (r_state == RUN) begin
            w_a     = r_opa[w_i*LIMB +: LIMB];
            w_b     = r_opb[w_j*LIMB +: LIMB];
            w_shamt = SW'(LIMB) * (SW'(w_i) + SW'(w_j));
        end
    end

    limb_mul #(.LIMB(LIMB)) u_limb_mul (
        .input0  (w_a),
        .input1  (w_b),
        .output0 (w_pp)
    );

`ifdef SEQ_LIMB_MUL_PIPE_EN
    assign w_add = PW'(r_pp) << r_shamt;
`else
    assign w_add = PW'(w_pp) << w_shamt;
`endif
    assign w_sum = r_acc + w_add;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (start) w_state_nxt = RUN;
`ifdef SEQ_LIMB_MUL_PIPE_EN
            RUN:  if (w_last) w_state_nxt = PIPE;
            PIPE: w_state_nxt = IDLE;
`else
            RUN:  if (w_last) w_state_nxt = IDLE;
`endif
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_n     <= '0;
            r_opa   <= '0;
            r_opb   <= '0;
            r_acc   <= '0;
            r_out   <= '0;
            r_ready <= 1'b0;
`ifdef SEQ_LIMB_MUL_PIPE_EN
            r_pp    <= '0;
            r_shamt <= '0;
`endif
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_opa <= input0;
                        r_opb <= input1;
                        r_acc <= '0;
                        r_n   <= '0;
`ifdef SEQ_LIMB_MUL_PIPE_EN
                        r_pp    <= '0;
                        r_shamt <= '0;
`endif
                    end
                end
                RUN: begin
                    r_acc <= w_sum;
                    r_n   <= w_last ? '0 : r_n + 1'b1;
`ifdef SEQ_LIMB_MUL_PIPE_EN
                    // Accumulation lags one step; the first RUN cycle adds the cleared r_pp.
                    r_pp    <= w_pp;
                    r_shamt <= w_shamt;
`else
                    if (w_last) begin
                        r_out   <= w_sum;
                        r_ready <= 1'b1;
                    end
`endif
                end
`ifdef SEQ_LIMB_MUL_PIPE_EN
                PIPE: begin
                    r_acc   <= w_sum;
                    r_out   <= w_sum;
                    r_ready <= 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    assign busy    = (r_state != IDLE);
    assign ready   = r_ready;
    assign output0 = r_out;

endmodule

// File: tb/tb_seq_limb_mul.sv
// Directed bench for seq_limb_mul: default 24/12 instance plus a 32/8 instance.
module tb_seq_limb_mul;

`ifdef SEQ_LIMB_MUL_PIPE_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif
    localparam int NPP_A = 4;
    localparam int NPP_B = 16;
    localparam int LAT_A = NPP_A + 1 + EXTRA;
    localparam int LAT_B = NPP_B + 1 + EXTRA;

    logic        clk;
    logic        rst;
    logic        a_start, b_start;
    logic [23:0] a_in0, a_in1;
    logic [31:0] b_in0, b_in1;
    logic        a_busy, a_rdy, b_busy, b_rdy;
    logic [47:0] a_out;
    logic [63:0] b_out;

    int n_checks = 0;
    int n_errors = 0;

    seq_limb_mul dut_a (
        .clk(clk), .rst(rst), .start(a_start), .input0(a_in0), .input1(a_in1),
        .busy(a_busy), .ready(a_rdy), .output0(a_out)
    );

    seq_limb_mul #(.WIDTH(32), .LIMB(8)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .input0(b_in0), .input1(b_in1),
        .busy(b_busy), .ready(b_rdy), .output0(b_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Operands scrambled at t+1 and a stray start at t+2 must not disturb the result.
    task automatic run_a(input string tag, input logic [23:0] a, input logic [23:0] b,
                         input logic [47:0] exp);
        logic [47:0] prev;
        prev    = a_out;
        a_start = 1'b1;
        a_in0   = a;
        a_in1   = b;
        tick();
        a_start = 1'b0;
        for (int c = 1; c <= LAT_A + 1; c++) begin
            if (c == 1) begin
                a_in0 = 24'($urandom);
                a_in1 = 24'($urandom);
            end
            a_start = (c == 2);
            chk($sformatf("%s_busy_c%0d", tag, c), 64'(a_busy), 64'(c < LAT_A));
            chk($sformatf("%s_ready_c%0d", tag, c), 64'(a_rdy), 64'(c == LAT_A));
            chk($sformatf("%s_out_c%0d", tag, c), 64'(a_out), 64'((c < LAT_A) ? prev : exp));
            tick();
        end
        a_start = 1'b0;
    endtask

    task automatic run_b(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp);
        b_start = 1'b1;
        b_in0   = a;
        b_in1   = b;
        tick();
        b_start = 1'b0;
        for (int c = 1; c <= LAT_B + 1; c++) begin
            chk($sformatf("%s_busy_c%0d", tag, c), 64'(b_busy), 64'(c < LAT_B));
            chk($sformatf("%s_ready_c%0d", tag, c), 64'(b_rdy), 64'(c == LAT_B));
            if (c == LAT_B) chk($sformatf("%s_out", tag), b_out, exp);
            tick();
        end
    endtask

    initial begin
        rst = 1'b1; a_start = 1'b0; b_start = 1'b0;
        a_in0 = '0; a_in1 = '0; b_in0 = '0; b_in1 = '0;
        tick();
        tick();
        chk("rst_a_busy", 64'(a_busy), 64'd0);
        chk("rst_a_ready", 64'(a_rdy), 64'd0);
        chk("rst_a_out", 64'(a_out), 64'd0);
        chk("rst_b_busy", 64'(b_busy), 64'd0);
        chk("rst_b_out", b_out, 64'd0);
        rst = 1'b0;
        tick();

        run_a("max", 24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001);
        run_a("small", 24'h123456, 24'h000002, 48'h0000002468AC);
        run_a("order", 24'h001002, 24'h003004, 48'h00000300A008);

        // Back-to-back: start held, operands switch to 7x9 while the first op runs.
        a_start = 1'b1; a_in0 = 24'd3; a_in1 = 24'd5;
        tick();
        for (int c = 1; c <= 2 * LAT_A + 1; c++) begin
            if (c == 1) begin
                a_in0 = 24'd7;
                a_in1 = 24'd9;
            end
            if (c == LAT_A + 1) a_start = 1'b0;
            chk($sformatf("b2b_ready_c%0d", c), 64'(a_rdy), 64'(c == LAT_A || c == 2 * LAT_A));
            if (c == LAT_A)     chk("b2b_out1", 64'(a_out), 64'd15);
            if (c == LAT_A + 1) chk("b2b_busy2", 64'(a_busy), 64'd1);
            if (c == 2 * LAT_A) chk("b2b_out2", 64'(a_out), 64'd63);
            tick();
        end

        // Reset in cycle t+2 aborts the operation and clears the held result.
        a_start = 1'b1; a_in0 = 24'hABCDEF; a_in1 = 24'h111111;
        tick();
        a_start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", 64'(a_busy), 64'd0);
        chk("abort_ready", 64'(a_rdy), 64'd0);
        chk("abort_out", 64'(a_out), 64'd0);
        for (int c = 0; c < LAT_A; c++) begin
            chk($sformatf("abort_noready_c%0d", c), 64'(a_rdy), 64'd0);
            tick();
        end
        run_a("after_rst", 24'hABCDEF, 24'h000001, 48'h000000ABCDEF);

        run_b("w32", 32'hDEADBEEF, 32'h01000001, 64'h00DEADBFCDADBEEF);
        run_b("w32max", 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
